pattern_memory: RTL and testbench
=================================

PATTERN_MEMORY -- requirements
Module: pattern_memory

Interface
REQ-001 Parameter WORD_SIZE, default 8, sets the data word width.
REQ-002 Parameter ADDRESS_SIZE, default 4, sets the address width.
REQ-003 Parameter MEMORY_QTY, default 16, sets the number of storage words; MEMORY_QTY <= 2^ADDRESS_SIZE.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous request to zero all locations.
REQ-007 w_en  input  1  write strobe, one word per cycle.
REQ-008 w_addr  input  ADDRESS_SIZE  write address.
REQ-009 w_data  input  WORD_SIZE  write data.
REQ-010 w_ready  output  1  high when writes are accepted.
REQ-011 r_en  input  1  read request from the sequencer, held until data is taken.
REQ-012 r_addr  input  ADDRESS_SIZE  read address.
REQ-013 r_ready  output  1  high when r_data is valid for the presented r_addr.
REQ-014 r_data  output  WORD_SIZE  read data.
REQ-015 addr_err  output  1  sticky flag set by any out-of-range access.

Function
REQ-016 The block SHALL implement a two-state FSM, CLEAR and READY, plus a clear pointer clr_addr of ADDRESS_SIZE bits.
REQ-017 In CLEAR, each cycle SHALL write 0 to mem[clr_addr] and increment clr_addr.
REQ-018 When clr_addr == MEMORY_QTY-1 in CLEAR, that location SHALL be zeroed, clr_addr SHALL return to 0, and the state SHALL move to READY on the same edge.
REQ-019 A full clear pass SHALL take exactly MEMORY_QTY cycles.
REQ-020 In READY, clear=1 SHALL move the FSM to CLEAR on the next edge, with clr_addr=0.
REQ-021 clear=1 while in CLEAR SHALL NOT restart the pass.
REQ-022 r_ready and w_ready SHALL be registered outputs, each equal to (state == READY).
REQ-023 A write SHALL occur on an edge only when w_en=1, w_ready=1, clear=0 and w_addr < MEMORY_QTY.
REQ-024 A write in the same cycle as a READY-state clear request SHALL be dropped; clear wins.
REQ-025 Writes while w_ready=0 SHALL be silently dropped and SHALL NOT set addr_err.
REQ-026 r_data SHALL be combinational: mem[r_addr] when r_en=1, r_ready=1 and r_addr < MEMORY_QTY; otherwise 0.
REQ-027 Read latency SHALL therefore be zero: data is valid in the same cycle r_en and r_addr are presented.
REQ-028 This guarantees a requester that asserts r_en and r_addr together captures correct data at the following edge.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old contents; the new value is visible from the next cycle.
REQ-030 r_addr >= MEMORY_QTY with r_en=1 and r_ready=1 SHALL return 0 and set addr_err.
REQ-031 w_addr >= MEMORY_QTY with an otherwise accepted write SHALL set addr_err and leave memory unchanged.
REQ-032 addr_err SHALL clear only on reset or on entry to CLEAR.
REQ-033 An address wrap of the requester from 2^ADDRESS_SIZE-1 to 0 needs no special handling; each access is range-checked independently.

Reset
REQ-034 reset_n=0 SHALL asynchronously force: state=CLEAR, clr_addr=0, r_ready=0, w_ready=0, addr_err=0.
REQ-035 r_data SHALL read 0 during reset because r_ready=0.
REQ-036 Memory contents SHALL NOT be asynchronously reset; they are zeroed by the CLEAR pass that starts after reset_n rises.
REQ-037 After reset_n deasserts, r_ready and w_ready SHALL rise after exactly MEMORY_QTY rising edges.
REQ-038 reset_n asserted during an active CLEAR pass SHALL restart the pass from address 0.

Verification
REQ-039 Reset release, defaults: count edges to r_ready=1 -> exactly 16; read all 16 addresses -> each returns 0x00.
REQ-040 Write 0xA5 to address 3, then r_en=1, r_addr=3 next cycle -> r_data=0xA5 in that same cycle; r_en=0 -> r_data=0x00.
REQ-041 Same-cycle write 0x3C and read at address 7 holding 0x11 -> read returns 0x11 that cycle and 0x3C the next.
REQ-042 clear pulse in READY together with a write of 0xFF to address 2 -> r_ready=0 for 16 cycles, address 2 reads 0x00, write dropped.
REQ-043 MEMORY_QTY=12, ADDRESS_SIZE=4: write to 13 and read of 14 -> memory unchanged, r_data=0, addr_err=1 until the next clear.
REQ-044 reset_n pulsed low at clear cycle 5 -> outputs low immediately; the pass restarts and r_ready rises 16 edges after release.

Source files
------------

// File: rtl/pattern_memory.sv
// pattern_memory: word store with a self-clearing pass
// and a zero-latency combinational read port.
module pattern_memory #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  output logic                    w_ready,
  input  logic                    r_en,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                    r_ready,
  output logic [WORD_SIZE-1:0]    r_data,
  output logic                    addr_err
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [ADDRESS_SIZE:0] QTY =
    (ADDRESS_SIZE+1)'(MEMORY_QTY);
  localparam logic [ADDRESS_SIZE-1:0] LAST =
    ADDRESS_SIZE'(MEMORY_QTY - 1);

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] clr_addr;
  logic                    ready;
  logic [WORD_SIZE-1:0]    mem [MEMORY_QTY];

  logic w_in;
  logic r_in;
  logic w_take;
  logic w_ok;
  logic w_bad;
  logic r_bad;

  // ready is high only in READY, so it also gates
  // every access; clear in READY beats a write
  assign w_in   = {1'b0, w_addr} < QTY;
  assign r_in   = {1'b0, r_addr} < QTY;
  assign w_take = w_en & ready & ~clear;
  assign w_ok   = w_take & w_in;
  assign w_bad  = w_take & ~w_in;
  assign r_bad  = r_en & ready & ~r_in;

  assign w_ready = ready;
  assign r_ready = ready;

  // out-of-range or not-ready reads return zero
  assign r_data = (r_en & ready & r_in) ?
                  mem[r_addr] : '0;

  // clear-pass sequencer, ready flag and sticky error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            clr_addr <= '0;
            state    <= READY;
            ready    <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        READY: begin
          if (clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
          end else if (w_bad | r_bad) begin
            addr_err <= 1'b1;
          end
        end
      endcase
    end
  end

  // storage has no reset; the clear pass zeroes it
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (w_ok) begin
      mem[w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_pattern_memory.sv
// tb_pattern_memory: scoreboard bench driving a 16-word
// and a 12-word instance against a reference model.
module tb_pattern_memory;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       w_en;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic       r_en;
  logic [3:0] r_addr;

  logic       a_w_ready, a_r_ready, a_err;
  logic [7:0] a_r_data;
  logic       b_w_ready, b_r_ready, b_err;
  logic [7:0] b_r_data;

  always #5 clock = ~clock;

  pattern_memory dut_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_ready  (a_w_ready),
    .r_en     (r_en),
    .r_addr   (r_addr),
    .r_ready  (a_r_ready),
    .r_data   (a_r_data),
    .addr_err (a_err)
  );

  pattern_memory #(.MEMORY_QTY(12)) dut_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_ready  (b_w_ready),
    .r_en     (r_en),
    .r_addr   (r_addr),
    .r_ready  (b_r_ready),
    .r_data   (b_r_data),
    .addr_err (b_err)
  );

  typedef struct packed {
    logic [1:0]      rdy;
    logic [1:0][7:0] d;
    logic [1:0]      e;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // model: contents, cycles left in a clear pass, error
  int         qty [2] = '{16, 12};
  logic [7:0] mm [2][16];
  int         busy [2];
  logic       err [2];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %h want %h",
               nm, cyc, act, req);
    end
  endtask

  task automatic model_zero(input int k);
    for (int j = 0; j < 16; j++) mm[k][j] = 8'h00;
  endtask

  task automatic drive(input logic rst,
                       input logic cl,
                       input logic we,
                       input logic [3:0] wa,
                       input logic [7:0] wd,
                       input logic re,
                       input logic [3:0] ra);
    exp_t x;
    @(posedge clock);
    #1;
    reset_n = ~rst;
    clear   = cl;
    w_en    = we;
    w_addr  = wa;
    w_data  = wd;
    r_en    = re;
    r_addr  = ra;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy[k] = qty[k];
        err[k]  = 1'b0;
        model_zero(k);
      end
      x.rdy[k] = (busy[k] == 0);
      x.e[k]   = err[k];
      x.d[k]   = (x.rdy[k] && re && ra < qty[k]) ?
                 mm[k][ra] : 8'h00;
      if (!rst) begin
        if (busy[k] > 0) begin
          busy[k]--;
        end else if (cl) begin
          busy[k] = qty[k];
          err[k]  = 1'b0;
          model_zero(k);
        end else begin
          if (we) begin
            if (wa < qty[k]) mm[k][wa] = wd;
            else err[k] = 1'b1;
          end
          if (re && ra >= qty[k]) err[k] = 1'b1;
        end
      end
    end
    sbq.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(0, 0, 0, 4'd0, 8'h00, 1, a);
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [7:0] d);
    drive(0, 0, 1, a, d, 0, 4'd0);
  endtask

  // monitor: compare outputs mid-cycle
  always @(negedge clock) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      cyc++;
      chk("a_r_ready", {7'd0, a_r_ready}, {7'd0, x.rdy[0]});
      chk("a_w_ready", {7'd0, a_w_ready}, {7'd0, x.rdy[0]});
      chk("a_r_data", a_r_data, x.d[0]);
      chk("a_addr_err", {7'd0, a_err}, {7'd0, x.e[0]});
      chk("b_r_ready", {7'd0, b_r_ready}, {7'd0, x.rdy[1]});
      chk("b_w_ready", {7'd0, b_w_ready}, {7'd0, x.rdy[1]});
      chk("b_r_data", b_r_data, x.d[1]);
      chk("b_addr_err", {7'd0, b_err}, {7'd0, x.e[1]});
    end
  end

  initial begin
    logic       rs, cl, we, re;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    reset_n = 1'b0;
    clear   = 1'b0;
    w_en    = 1'b0;
    w_addr  = 4'd0;
    w_data  = 8'h00;
    r_en    = 1'b0;
    r_addr  = 4'd0;
    for (int k = 0; k < 2; k++) begin
      busy[k] = qty[k];
      err[k]  = 1'b0;
      model_zero(k);
    end

    // reset, release, wait out the pass, read all
    for (int i = 0; i < 3; i++)
      drive(1, 0, 0, 4'd0, 8'h00, 1, 4'd0);
    idle(17);
    for (int i = 0; i < 16; i++) rd(4'(i));

    // write then zero-latency read, then r_en low
    wr(4'd3, 8'hA5);
    rd(4'd3);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 4'd3);

    // same-cycle read/write returns old data
    wr(4'd7, 8'h11);
    drive(0, 0, 1, 4'd7, 8'h3C, 1, 4'd7);
    rd(4'd7);

    // clear beats a simultaneous write
    drive(0, 1, 1, 4'd2, 8'hFF, 0, 4'd0);
    for (int i = 0; i < 17; i++) rd(4'd2);

    // out-of-range write and read, sticky error
    wr(4'd5, 8'h5A);
    wr(4'd13, 8'h77);
    rd(4'd14);
    rd(4'd13);
    rd(4'd5);
    idle(3);
    drive(0, 1, 0, 4'd0, 8'h00, 0, 4'd0);
    idle(17);
    rd(4'd13);

    // reset in the middle of a clear pass
    drive(0, 1, 0, 4'd0, 8'h00, 0, 4'd0);
    idle(5);
    drive(1, 0, 0, 4'd0, 8'h00, 1, 4'd1);
    drive(1, 0, 0, 4'd0, 8'h00, 1, 4'd1);
    for (int i = 0; i < 18; i++) rd(4'd1);

    // wrap of the requester address
    wr(4'd15, 8'hC3);
    wr(4'd0, 8'h3C);
    rd(4'd15);
    rd(4'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      cl = ($urandom_range(0, 79) == 0);
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      drive(rs, cl, we, wa, wd, re, ra);
    end

    @(negedge clock);
    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d left want 0",
               sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
